reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: RST_N  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: ADR1  in  5  read address, port 1.
REQ-004 SHALL have port: ADR2  in  5  read address, port 2.
REQ-005 SHALL have port: RS1  out  32  read data, port 1.
REQ-006 SHALL have port: RS2  out  32  read data, port 2.
REQ-007 SHALL have port: RS1_BUSY  out  1  ADR1 has a live pending load.
REQ-008 SHALL have port: RS2_BUSY  out  1  ADR2 has a live pending load.
REQ-009 SHALL have port: EN  in  1  write enable, write-back mux path.
REQ-010 SHALL have port: WA  in  5  write address, write-back mux path.
REQ-011 SHALL have port: WD  in  32  write data from the write-back select mux.
REQ-012 SHALL have port: LD_ISSUE  in  1  load issued; enqueue destination.
REQ-013 SHALL have port: LD_RD  in  5  load destination register.
REQ-014 SHALL have port: LD_VALID  in  1  load data returned, in issue order.
REQ-015 SHALL have port: LD_DATA  in  32  returned load word.
REQ-016 SHALL have port: LQ_FULL  out  1  load queue holds 2 entries.
REQ-017 SHALL have port: LQ_EMPTY  out  1  load queue holds 0 entries.
REQ-018 SHALL have port: LQ_OVF  out  1  sticky: issue attempted while full.

Function
REQ-019 SHALL hold 32 x 32-bit registers; x0 reads 0 always; writes to x0 discarded.
REQ-020 SHALL read RS1/RS2 combinationally from the array; no write-to-read bypass (same-cycle write visible next cycle).
REQ-021 SHALL write WD to WA on the clock edge when EN=1 and WA!=0.
REQ-022 SHALL keep a 2-entry in-order load queue; each entry: rd[4:0], kill bit, valid bit.
REQ-023 SHALL enqueue {LD_RD, kill=0} on LD_ISSUE=1 when not full; with queue full and no same-cycle retire, issue ignored and LQ_OVF set until reset.
REQ-024 SHALL retire head entry on LD_VALID=1 when not empty: writes LD_DATA to head rd unless kill=1 or rd=0; LD_VALID while empty ignored, no write.
REQ-025 SHALL allow simultaneous issue and retire in any occupancy, including full (count unchanged, no overflow).
REQ-026 SHALL set kill on every live entry with rd==WA when EN=1 and WA!=0 (younger ALU write supersedes older load).
REQ-027 SHALL NOT set kill on an entry enqueued in the same cycle as the EN write (that load is younger).
REQ-028 SHALL, when EN write and load retire target the same register in one cycle, store WD (load retires with kill applied).
REQ-029 SHALL, when EN write and load retire target different registers in one cycle, perform both writes.
REQ-030 SHALL drive RSn_BUSY=1 iff ADRn!=0 and some valid entry has rd==ADRn and kill=0; combinational from current state.
REQ-031 SHALL drive LQ_FULL=(count==2), LQ_EMPTY=(count==0) from registered count.

Reset
REQ-032 SHALL on RST_N=0, asynchronously: clear all 32 registers to 0, empty queue, clear kill/valid bits, clear LQ_OVF; outputs RS1=RS2=0, busy=0, LQ_EMPTY=1, LQ_FULL=0.
REQ-033 SHALL discard in-flight loads on reset mid-operation; LD_VALID in first cycle after release ignored (queue empty).

Verification
REQ-034 SHALL cover: EN=1,WA=5,WD=0xDEADBEEF; next cycle ADR1=5 -> RS1=0xDEADBEEF; same cycle RS1=old value 0.
REQ-035 SHALL cover: LD_ISSUE rd=7; ADR2=7 -> RS2_BUSY=1; LD_VALID,LD_DATA=0x1234 -> next cycle RS2=0x1234, RS2_BUSY=0, LQ_EMPTY=1.
REQ-036 SHALL cover: issue rd=3, issue rd=4 (LQ_FULL=1), third issue -> LQ_OVF=1, count stays 2; retire twice in order -> x3, x4 written.
REQ-037 SHALL cover: issue rd=9, then EN WA=9 WD=0xAA -> busy(9)=0; retire LD_DATA=0xBB -> x9 stays 0xAA.
REQ-038 SHALL cover: EN WA=0 WD=0xFF and load rd=0 retire -> RS1 at ADR1=0 stays 0, busy never set.
REQ-039 SHALL cover: full queue, RST_N pulsed low mid-cycle -> immediate empty, all registers 0, LQ_OVF=0.

Source files
------------

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_sb_if : read / write-back / load-queue bundle for reg_file_sb   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface reg_file_sb_if;
  logic [4:0]  ADR1;
  logic [4:0]  ADR2;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic        RS1_BUSY;
  logic        RS2_BUSY;
  logic        EN;
  logic [4:0]  WA;
  logic [31:0] WD;
  logic        LD_ISSUE;
  logic [4:0]  LD_RD;
  logic        LD_VALID;
  logic [31:0] LD_DATA;
  logic        LQ_FULL;
  logic        LQ_EMPTY;
  logic        LQ_OVF;

  modport master (
    output ADR1, ADR2, EN, WA, WD, LD_ISSUE, LD_RD, LD_VALID, LD_DATA,
    input  RS1, RS2, RS1_BUSY, RS2_BUSY, LQ_FULL, LQ_EMPTY, LQ_OVF
  );

  modport slave (
    input  ADR1, ADR2, EN, WA, WD, LD_ISSUE, LD_RD, LD_VALID, LD_DATA,
    output RS1, RS2, RS1_BUSY, RS2_BUSY, LQ_FULL, LQ_EMPTY, LQ_OVF
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_sb : 32x32 register file with a 2-entry in-order load scoreboard|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module reg_file_sb (
  input  logic         CLK,
  input  logic         RST_N,
  reg_file_sb_if.slave bus
);
  localparam int unsigned NREGS    = 32;
  localparam int unsigned LQ_DEPTH = 2;

  logic [31:0]         regs  [NREGS];
  logic [4:0]          q_rd  [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] q_kill;
  logic [LQ_DEPTH-1:0] q_valid;
  logic [1:0]          count;
  logic                ovf;

  logic                alu_wr;
  logic                retire;
  logic                issue_ok;
  logic                ovf_set;
  logic                ld_wr;
  logic [LQ_DEPTH-1:0] kill_now;
  logic [1:0]          count_after;
  logic [1:0]          count_nxt;
  logic [4:0]          rd_nxt    [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] kill_nxt;
  logic [LQ_DEPTH-1:0] valid_nxt;
  logic                busy1;
  logic                busy2;

  always_comb begin
    alu_wr   = bus.EN && (bus.WA != 5'd0);
    retire   = bus.LD_VALID && (count != 2'd0);
    issue_ok = bus.LD_ISSUE && ((count != 2'd2) || retire);
    ovf_set  = bus.LD_ISSUE && (count == 2'd2) && !retire;

    // An ALU write supersedes every older pending load to the same register,
    // including the head retiring this very cycle.
    for (int i = 0; i < LQ_DEPTH; i++) begin
      kill_now[i] = q_kill[i] | (q_valid[i] && alu_wr && (q_rd[i] == bus.WA));
    end
    ld_wr = retire && !kill_now[0] && (q_rd[0] != 5'd0);

    for (int i = 0; i < LQ_DEPTH; i++) begin
      rd_nxt[i] = q_rd[i];
    end
    kill_nxt    = kill_now;
    valid_nxt   = q_valid;
    count_after = count;
    if (retire) begin
      rd_nxt[0]    = q_rd[1];
      kill_nxt[0]  = kill_now[1];
      valid_nxt[0] = q_valid[1];
      rd_nxt[1]    = 5'd0;
      kill_nxt[1]  = 1'b0;
      valid_nxt[1] = 1'b0;
      count_after  = count - 2'd1;
    end

    // A newly issued load is younger than a same-cycle ALU write: no kill.
    if (issue_ok) begin
      if (count_after == 2'd0) begin
        rd_nxt[0]    = bus.LD_RD;
        kill_nxt[0]  = 1'b0;
        valid_nxt[0] = 1'b1;
      end else begin
        rd_nxt[1]    = bus.LD_RD;
        kill_nxt[1]  = 1'b0;
        valid_nxt[1] = 1'b1;
      end
    end
    count_nxt = count_after + {1'b0, issue_ok};

    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (q_valid[i] && !q_kill[i] && (q_rd[i] == bus.ADR1) && (bus.ADR1 != 5'd0)) busy1 = 1'b1;
      if (q_valid[i] && !q_kill[i] && (q_rd[i] == bus.ADR2) && (bus.ADR2 != 5'd0)) busy2 = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 32'd0;
      end
      for (int i = 0; i < LQ_DEPTH; i++) begin
        q_rd[i] <= 5'd0;
      end
      q_kill  <= '0;
      q_valid <= '0;
      count   <= 2'd0;
      ovf     <= 1'b0;
    end else begin
      if (ld_wr)  regs[q_rd[0]] <= bus.LD_DATA;
      if (alu_wr) regs[bus.WA]  <= bus.WD;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        q_rd[i] <= rd_nxt[i];
      end
      q_kill  <= kill_nxt;
      q_valid <= valid_nxt;
      count   <= count_nxt;
      if (ovf_set) ovf <= 1'b1;
    end
  end

  // x0 is cleared by reset and never written, so it reads back as zero.
  assign bus.RS1      = regs[bus.ADR1];
  assign bus.RS2      = regs[bus.ADR2];
  assign bus.RS1_BUSY = busy1;
  assign bus.RS2_BUSY = busy2;
  assign bus.LQ_FULL  = (count == 2'd2);
  assign bus.LQ_EMPTY = (count == 2'd0);
  assign bus.LQ_OVF   = ovf;
endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_file_sb : vector table + scoreboard bench for reg_file_sb         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_reg_file_sb;
  logic CLK;
  logic RST_N;

  reg_file_sb_if bus ();

  reg_file_sb dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  lrd;
    logic        lv;
    logic [31:0] ldd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        b1;
    logic        b2;
    logic        full;
    logic        empty;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t V(input string nm,
                             input int unsigned en, input int unsigned wa, input int unsigned wd,
                             input int unsigned iss, input int unsigned lrd,
                             input int unsigned lv, input int unsigned ldd,
                             input int unsigned a1, input int unsigned a2,
                             input int unsigned rs1, input int unsigned rs2,
                             input int unsigned b1, input int unsigned b2,
                             input int unsigned full, input int unsigned empty, input int unsigned ovf);
    vec_t v;
    v.name = nm;
    v.en = 1'(en);   v.wa = 5'(wa);   v.wd = 32'(wd);
    v.iss = 1'(iss); v.lrd = 5'(lrd); v.lv = 1'(lv); v.ldd = 32'(ldd);
    v.a1 = 5'(a1);   v.a2 = 5'(a2);
    v.rs1 = 32'(rs1); v.rs2 = 32'(rs2);
    v.b1 = 1'(b1); v.b2 = 1'(b2);
    v.full = 1'(full); v.empty = 1'(empty); v.ovf = 1'(ovf);
    return v;
  endfunction

  task automatic chk_field(input string vn, input string f, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s.%s: got %h expected %h (t=%0t)", vn, f, act, exp, $time);
    end
  endtask

  task automatic compare(input vec_t e);
    n_vec++;
    chk_field(e.name, "RS1",      bus.RS1,              e.rs1);
    chk_field(e.name, "RS2",      bus.RS2,              e.rs2);
    chk_field(e.name, "RS1_BUSY", {31'd0, bus.RS1_BUSY}, {31'd0, e.b1});
    chk_field(e.name, "RS2_BUSY", {31'd0, bus.RS2_BUSY}, {31'd0, e.b2});
    chk_field(e.name, "LQ_FULL",  {31'd0, bus.LQ_FULL},  {31'd0, e.full});
    chk_field(e.name, "LQ_EMPTY", {31'd0, bus.LQ_EMPTY}, {31'd0, e.empty});
    chk_field(e.name, "LQ_OVF",   {31'd0, bus.LQ_OVF},   {31'd0, e.ovf});
  endtask

  task automatic drive(input vec_t v);
    bus.EN = v.en;       bus.WA = v.wa;       bus.WD = v.wd;
    bus.LD_ISSUE = v.iss; bus.LD_RD = v.lrd;
    bus.LD_VALID = v.lv; bus.LD_DATA = v.ldd;
    bus.ADR1 = v.a1;     bus.ADR2 = v.a2;
  endtask

  // Inputs change just after the active edge; expectations describe outputs
  // seen during that cycle, before the next edge commits the state change.
  task automatic apply(input vec_t v);
    @(posedge CLK);
    #1;
    drive(v);
    sb.push_back(v);
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      compare(mon_e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           name            en wa wd            is rd lv ldd           a1 a2 rs1           rs2           b1 b2 fu em ov
    tbl.push_back(V("wr5",        1, 5, 32'hDEADBEEF, 0, 0, 0, 0,            5, 0, 0,            0,            0, 0, 0, 1, 0));
    tbl.push_back(V("rd5",        0, 0, 0,            0, 0, 0, 0,            5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 1, 0));
    tbl.push_back(V("iss7",       0, 0, 0,            1, 7, 0, 0,            0, 7, 0,            0,            0, 0, 0, 1, 0));
    tbl.push_back(V("busy7",      0, 0, 0,            0, 0, 0, 0,            7, 7, 0,            0,            1, 1, 0, 0, 0));
    tbl.push_back(V("ret7",       0, 0, 0,            0, 0, 1, 32'h1234,     0, 7, 0,            0,            0, 1, 0, 0, 0));
    tbl.push_back(V("rd7",        0, 0, 0,            0, 0, 0, 0,            7, 7, 32'h1234,     32'h1234,     0, 0, 0, 1, 0));
    tbl.push_back(V("iss3",       0, 0, 0,            1, 3, 0, 0,            3, 4, 0,            0,            0, 0, 0, 1, 0));
    tbl.push_back(V("iss4",       0, 0, 0,            1, 4, 0, 0,            3, 4, 0,            0,            1, 0, 0, 0, 0));
    tbl.push_back(V("iss_full",   0, 0, 0,            1,10, 0, 0,            3, 4, 0,            0,            1, 1, 1, 0, 0));
    tbl.push_back(V("ovf",        0, 0, 0,            0, 0, 0, 0,           10, 4, 0,            0,            0, 1, 1, 0, 1));
    tbl.push_back(V("ret3",       0, 0, 0,            0, 0, 1, 32'h33,       3, 4, 0,            0,            1, 1, 1, 0, 1));
    tbl.push_back(V("ret4",       0, 0, 0,            0, 0, 1, 32'h44,       3, 4, 32'h33,       0,            0, 1, 0, 0, 1));
    tbl.push_back(V("rd34",       0, 0, 0,            0, 0, 0, 0,            3, 4, 32'h33,       32'h44,       0, 0, 0, 1, 1));
    tbl.push_back(V("iss9",       0, 0, 0,            1, 9, 0, 0,            9, 9, 0,            0,            0, 0, 0, 1, 1));
    tbl.push_back(V("wr9",        1, 9, 32'hAA,       0, 0, 0, 0,            9, 0, 0,            0,            1, 0, 0, 0, 1));
    tbl.push_back(V("kill9",      0, 0, 0,            0, 0, 0, 0,            9, 9, 32'hAA,       32'hAA,       0, 0, 0, 0, 1));
    tbl.push_back(V("ret9",       0, 0, 0,            0, 0, 1, 32'hBB,       9, 0, 32'hAA,       0,            0, 0, 0, 0, 1));
    tbl.push_back(V("rd9",        0, 0, 0,            0, 0, 0, 0,            9, 9, 32'hAA,       32'hAA,       0, 0, 0, 1, 1));
    tbl.push_back(V("x0_wr_iss",  1, 0, 32'hFF,       1, 0, 0, 0,            0, 0, 0,            0,            0, 0, 0, 1, 1));
    tbl.push_back(V("x0_ret",     0, 0, 0,            0, 0, 1, 32'h55,       0, 0, 0,            0,            0, 0, 0, 0, 1));
    tbl.push_back(V("lv_empty",   0, 0, 0,            0, 0, 1, 32'h77,       0, 9, 0,            32'hAA,       0, 0, 0, 1, 1));
    tbl.push_back(V("after_lv",   0, 0, 0,            0, 0, 0, 0,            9, 0, 32'hAA,       0,            0, 0, 0, 1, 1));

    drive(V("idle", 0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0,1,0));
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2 compare(V("reset", 0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0,1,0));
    #9 RST_N = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Same-cycle issue is younger than the ALU write; full-queue swap with a kill.
    apply(V("iss_wr12",     1,12,32'h1200, 1,12, 0,0,          12, 0, 0,          0,          0,0,0,1,1));
    apply(V("young12",      0, 0,0,        0, 0, 0,0,          12,12, 32'h1200,   32'h1200,   1,1,0,0,1));
    apply(V("iss13",        0, 0,0,        1,13, 0,0,          12,13, 32'h1200,   0,          1,0,0,0,1));
    apply(V("full_iss_ret", 1,13,32'h1313, 1,14, 1,32'hC0C0,   12,13, 32'h1200,   0,          1,1,1,0,1));
    apply(V("post_swap",    0, 0,0,        0, 0, 0,0,          13,14, 32'h1313,   0,          0,1,1,0,1));
    apply(V("ret_killed13", 0, 0,0,        0, 0, 1,32'hDEAD,   12,13, 32'hC0C0,   32'h1313,   0,0,1,0,1));
    apply(V("ret_wr14",     1,14,32'h1414, 0, 0, 1,32'h0BAD,   14,13, 0,          32'h1313,   1,0,0,0,1));
    apply(V("rd14",         0, 0,0,        0, 0, 0,0,          14,12, 32'h1414,   32'hC0C0,   0,0,0,1,1));

    // Fill the queue, then pulse reset in the middle of a cycle.
    apply(V("r_iss20",      0, 0,0,        1,20, 0,0,          20,21, 0,          0,          0,0,0,1,1));
    apply(V("r_iss21",      0, 0,0,        1,21, 0,0,          20,21, 0,          0,          1,0,0,0,1));
    apply(V("r_full",       0, 0,0,        0, 0, 0,0,          20,21, 0,          0,          1,1,1,0,1));
    @(negedge CLK);
    #2;
    drive(V("idle", 0,0,0, 0,0, 0,0, 3,12, 0,0, 0,0,0,1,0));
    RST_N = 1'b0;
    #1 compare(V("rst_mid",  0,0,0, 0,0, 0,0, 3,12, 0,0, 0,0,0,1,0));
    @(posedge CLK);
    #1 compare(V("rst_hold", 0,0,0, 0,0, 0,0, 3,12, 0,0, 0,0,0,1,0));
    @(negedge CLK);
    #2;
    drive(V("lv_post", 0,0,0, 0,0, 1,32'h99, 3,12, 0,0, 0,0,0,1,0));
    RST_N = 1'b1;
    apply(V("post_rst",     0, 0,0,        0, 0, 0,0,           3,12, 0,          0,          0,0,0,1,0));

    // Simultaneous issue and retire on a full queue must not overflow.
    apply(V("c_iss20",      0, 0,0,        1,20, 0,0,          20,21, 0,          0,          0,0,0,1,0));
    apply(V("c_iss21",      0, 0,0,        1,21, 0,0,          20,21, 0,          0,          1,0,0,0,0));
    apply(V("c_full_swap",  0, 0,0,        1,22, 1,32'h2020,   20,22, 0,          0,          1,0,1,0,0));
    apply(V("c_after",      0, 0,0,        0, 0, 0,0,          20,22, 32'h2020,   0,          0,1,1,0,0));

    @(posedge CLK);
    #1 drive(V("idle", 0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0,1,0));
    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
